rv_fifo_with_level: RTL and testbench
=====================================

Name: rv_fifo_with_level

Overview:
- Parametrised ready/valid (AXI-Stream rules) flip-flop FIFO.
- Successor to the plain push/pop counter FIFO used for operand delay-matching beside the FP arithmetic pipelines, e.g. holding b and c while a^5 is computed.
- Adds a ready/valid handshake on both sides, push-when-full-with-pop, level output, programmable almost-full/almost-empty flags, and non-power-of-2 depth.
- Sits between an argument source and an arithmetic wrapper, or between pipeline stages.

Parameters:
- WIDTH, 32, data width in bits; FP operand width.
- DEPTH, 10, number of entries; any value >= 2, power of 2 not required.
- AFULL_LVL, DEPTH-2, almost_full asserts when level >= AFULL_LVL.
- AEMPTY_LVL, 1, almost_empty asserts when level <= AEMPTY_LVL.
- ALLOW_PUSH_WHEN_FULL_WITH_POP, 1, when 1 up_rdy is also high while full if down_rdy is high.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- up_vld  input  1  write data valid.
- up_rdy  output  1  FIFO can accept up_data this cycle.
- up_data  input  WIDTH  write data.
- down_vld  output  1  head entry valid.
- down_rdy  input  1  consumer accepts head this cycle.
- down_data  output  WIDTH  head entry (first-word fall-through).
- level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  output  1  level >= AFULL_LVL.
- almost_empty  output  1  level <= AEMPTY_LVL.

Behaviour:
- Reset (asynchronous, active-high, clock clk): wr_ptr=0, rd_ptr=0, level=0; down_vld=0, up_rdy=1, almost_empty=1, almost_full=(AFULL_LVL==0). Storage array is not reset; down_data is don't-care while down_vld=0.
- push = up_vld & up_rdy; pop = down_vld & down_rdy.
- down_vld = (level != 0).
- up_rdy = (level != DEPTH), OR'd with down_rdy when ALLOW_PUSH_WHEN_FULL_WITH_POP=1. up_rdy never depends on up_vld.
- Write: on push, mem[wr_ptr] <= up_data. wr_ptr wraps DEPTH-1 -> 0 by compare, not by modulo-2^n.
- Read: down_data = mem[rd_ptr], combinational from registers. On pop, rd_ptr advances with the same wrap rule.
- Level update:
  - push & ~pop: +1
  - pop & ~push: -1
  - push & pop: unchanged, both pointers advance.
- Latency: a word pushed into an empty FIFO at edge N appears with down_vld=1 after edge N. Minimum latency 1 cycle.
- Throughput: one push and one pop per cycle sustained, with no bubbles at any level including full (when the parameter is 1).
- Boundaries:
  - Full with down_rdy=0: up_rdy=0; up_vld is ignored and data is held.
  - Full with down_rdy=1 (parameter 1): simultaneous push/pop, level stays at DEPTH.
  - Empty: down_vld=0; down_rdy is ignored, with no pointer movement or underflow.
  - Pointers wrap correctly across any number of passes.
- Reset mid-traffic discards all contents immediately, independent of clk.
- All flags are combinational from level only, with no glitch paths from up_vld.

Optional Feature:
- Macro: RV_FIFO_BYPASS_EN.
- Defined: when level==0 and up_vld & down_rdy, up_data is routed directly to down_data with down_vld=1 in the same cycle. Nothing is written, pointers and level are unchanged, and latency is 0.
- Not defined: no combinational up->down path; minimum latency 1 cycle as above.

Decomposition:
- Package rv_fifo_pkg: function for pointer width ($clog2(DEPTH) with a minimum of 1) and level width ($clog2(DEPTH+1)); typedef for the level type is generated per instance via localparam.
- One sub-module, rv_fifo_wrap_ptr: a parametrised modulo-DEPTH pointer register with enable, instanced for rd and wr.

Test Plan:
- Reset then idle -> level=0, down_vld=0, up_rdy=1, almost_empty=1, almost_full=0.
- DEPTH=10: push 0x1..0xA with down_rdy=0 -> level=10, up_rdy=0, almost_full=1 from level 8; an 11th up_vld is not accepted.
- Full, then up_vld=1 and down_rdy=1 for 20 cycles with data 0x100+i -> output 0x1..0xA then 0x100.., level stays 10, no bubble.
- Random up_vld/down_rdy for 10k cycles with a scoreboard queue -> exact order match, level equals queue size, pointers wrap at 9->0.
- Assert rst mid-stream with level=5, asynchronously between edges -> level=0 and down_vld=0 immediately; next push 0xAB is popped first.
- With RV_FIFO_BYPASS_EN: empty FIFO, up_vld=1, up_data=0x55, down_rdy=1 -> down_vld=1 and down_data=0x55 in the same cycle, level remains 0. Without the macro, 0x55 appears next cycle.

Source files
------------

// File: rtl/rv_fifo_pkg.sv
// Shared sizing helpers for the ready/valid FIFO with occupancy level.
package rv_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rv_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer register; wraps DEPTH-1 -> 0 by compare so any depth works.
module rv_fifo_wrap_ptr #(
    parameter int DEPTH = 10,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/rv_fifo_with_level.sv
// Flip-flop FIFO with ready/valid on both sides, level output and almost flags.
// Optional same-cycle empty bypass when RV_FIFO_BYPASS_EN is defined.
module rv_fifo_with_level
    import rv_fifo_pkg::*;
#(
    parameter int WIDTH                         = 32,
    parameter int DEPTH                         = 10,
    parameter int AFULL_LVL                     = DEPTH - 2,
    parameter int AEMPTY_LVL                    = 1,
    parameter int ALLOW_PUSH_WHEN_FULL_WITH_POP = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         up_vld,
    output logic                         up_rdy,
    input  logic [WIDTH-1:0]             up_data,
    output logic                         down_vld,
    input  logic                         down_rdy,
    output logic [WIDTH-1:0]             down_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int LVL_W = level_width(DEPTH);
    typedef logic [LVL_W-1:0] level_t;

    // Handshake: a transfer happens on a rising edge where vld and rdy are both
    // high; rdy never looks at the same side's vld, so there is no comb loop.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    level_t           level_q;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             push;
    logic             pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == level_t'(DEPTH));

`ifdef RV_FIFO_BYPASS_EN
    assign bypass = empty & up_vld & down_rdy;
`else
    assign bypass = 1'b0;
`endif

    assign up_rdy    = ~full | ((ALLOW_PUSH_WHEN_FULL_WITH_POP != 0) & down_rdy);
    assign down_vld  = ~empty | bypass;
    assign down_data = bypass ? up_data : mem[rd_ptr];

    // A bypassed word never touches storage, pointers or level.
    assign push = up_vld & up_rdy & ~bypass;
    assign pop  = down_vld & down_rdy & ~bypass;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= up_data;
        end
    end

    rv_fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push),
        .ptr (wr_ptr)
    );

    rv_fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level_q <= level_q + level_t'(1);
                2'b01:   level_q <= level_q - level_t'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign level        = level_q;
    assign almost_full  = (32'(level_q) >= AFULL_LVL);
    assign almost_empty = (32'(level_q) <= AEMPTY_LVL);

endmodule

// File: tb/tb_rv_fifo_with_level.sv
// Directed and scoreboarded bench for rv_fifo_with_level (DEPTH=10, WIDTH=32).
module tb_rv_fifo_with_level;

    localparam int WIDTH = 32;
    localparam int DEPTH = 10;

    logic             clk;
    logic             rst;
    logic             up_vld;
    logic             up_rdy;
    logic [WIDTH-1:0] up_data;
    logic             down_vld;
    logic             down_rdy;
    logic [WIDTH-1:0] down_data;
    logic [3:0]       level;
    logic             almost_full;
    logic             almost_empty;

    int checks;
    int errors;
    logic [WIDTH-1:0] exp_q[$];

    rv_fifo_with_level #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_vld       (up_vld),
        .up_rdy       (up_rdy),
        .up_data      (up_data),
        .down_vld     (down_vld),
        .down_rdy     (down_rdy),
        .down_data    (down_data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks: inputs change at posedge+1, outputs are sampled at posedge+2
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
        up_vld   = v;
        up_data  = d;
        down_rdy = r;
    endtask

    initial begin
        logic byp, exp_vld, exp_rdy, do_pop, do_push;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, '0, 1'b0);
        #12 rst = 1'b0;
        tick();

        // reset state
        #1;
        check("rst_level", level, 0);
        check("rst_down_vld", down_vld, 0);
        check("rst_up_rdy", up_rdy, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_afull", almost_full, 0);

        // empty: down_rdy ignored
        drive(1'b0, '0, 1'b1);
        tick();
        check("empty_pop_level", level, 0);
        check("empty_pop_vld", down_vld, 0);

        // fill 0x1..0xA with no consumer
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, WIDTH'(i), 1'b0);
            #1;
            check("fill_up_rdy", up_rdy, 1);
            exp_q.push_back(WIDTH'(i));
            tick();
            check("fill_level", level, i);
            check("fill_afull", almost_full, (i >= 8));
            check("fill_aempty", almost_empty, (i <= 1));
        end
        check("full_up_rdy", up_rdy, 0);

        // 11th word refused, contents held
        drive(1'b1, 32'hEE, 1'b0);
        #1;
        check("full_up_rdy_vld", up_rdy, 0);
        tick();
        check("full_hold_level", level, DEPTH);
        check("full_hold_data", down_data, 32'h1);

        // full streaming: push and pop every cycle, level stays at DEPTH
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, WIDTH'(32'h100 + i), 1'b1);
            #1;
            check("stream_down_vld", down_vld, 1);
            check("stream_up_rdy", up_rdy, 1);
            check("stream_data", down_data, (i < DEPTH) ? 32'(i + 1) : 32'(32'h100 + i - DEPTH));
            void'(exp_q.pop_front());
            exp_q.push_back(up_data);
            tick();
            check("stream_level", level, DEPTH);
        end

        // random traffic against the scoreboard queue
        for (int c = 0; c < 10000; c++) begin
            if (c < 5000) drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1);
            else          drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0);
            #1;
            byp = 1'b0;
`ifdef RV_FIFO_BYPASS_EN
            byp = (exp_q.size() == 0) && up_vld && down_rdy;
`endif
            exp_vld = (exp_q.size() != 0) || byp;
            exp_rdy = (exp_q.size() != DEPTH) || down_rdy;
            check("rnd_down_vld", down_vld, exp_vld);
            check("rnd_up_rdy", up_rdy, exp_rdy);
            if (byp) begin
                check("rnd_bypass_data", down_data, up_data);
            end else begin
                do_pop  = exp_vld && down_rdy;
                do_push = up_vld && exp_rdy;
                if (do_pop) begin
                    check("rnd_down_data", down_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                if (do_push) exp_q.push_back(up_data);
            end
            tick();
            check("rnd_level", level, exp_q.size());
        end

        // asynchronous reset with 5 words stored
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, WIDTH'(32'h200 + i), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        check("pre_rst_level", level, 5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_level", level, 0);
        check("async_rst_down_vld", down_vld, 0);
        check("async_rst_up_rdy", up_rdy, 1);
        #2 rst = 1'b0;
        tick();
        drive(1'b1, 32'hAB, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1);
        #1;
        check("post_rst_vld", down_vld, 1);
        check("post_rst_data", down_data, 32'hAB);
        check("post_rst_level", level, 1);
        tick();
        drive(1'b0, '0, 1'b0);
        #1;
        check("post_rst_drain", level, 0);

        // empty FIFO, producer and consumer both active
        drive(1'b1, 32'h55, 1'b1);
        #1;
`ifdef RV_FIFO_BYPASS_EN
        check("byp_down_vld", down_vld, 1);
        check("byp_down_data", down_data, 32'h55);
        tick();
        drive(1'b0, '0, 1'b0);
        #1;
        check("byp_level", level, 0);
        check("byp_after_vld", down_vld, 0);
`else
        check("lat_down_vld_now", down_vld, 0);
        tick();
        drive(1'b0, '0, 1'b0);
        #1;
        check("lat_down_vld_next", down_vld, 1);
        check("lat_down_data_next", down_data, 32'h55);
        check("lat_level", level, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
